spike_isi_encoder: RTL and testbench

SPIKE_ISI_ENCODER -- requirements
Module: spike_isi_encoder

---
 rtl/spike_isi_encoder_pkg.sv | 10 +
 rtl/spike_isi_encoder_isi_fifo.sv | 59 +++++
 rtl/spike_isi_encoder.sv | 122 ++++++++++++
 tb/tb_spike_isi_encoder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/spike_isi_encoder_pkg.sv
// Shared neuron package for the spike ISI encoder: default geometry,
// the ISI saturation value and the rate window length.
package spike_isi_encoder_pkg;

  localparam int DEF_DEPTH    = 4;
  localparam int DEF_ISI_W    = 8;
  localparam int ISI_SAT      = (1 << DEF_ISI_W) - 1;
  localparam int RATE_WIN_LEN = 256;

endpackage

// File: rtl/spike_isi_encoder_isi_fifo.sv
// isi_fifo: small circular FIFO holding inter-spike intervals.
// A push into a full FIFO is accepted only when a pop frees the head slot
// in the same cycle. Pointers wrap naturally because DEPTH is a power of two.
module isi_fifo
  import spike_isi_encoder_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int ISI_W = DEF_ISI_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [ISI_W-1:0]         wdata,
  input  logic                     pop,
  output logic [ISI_W-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [ISI_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Head is forced to zero when nothing is queued so storage needs no reset.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage write; data path carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/spike_isi_encoder.sv
// spike_isi_encoder: measures the interval between rising spike edges from an
// upstream QIF neuron and queues the intervals for a consumer.
// The first edge after reset only arms the encoder. Intervals saturate at
// 2^ISI_W-1. Optional per-window spike rate counter is built when the macro
// SPIKE_RATE_WINDOW_EN is defined (adds ports rate_count and rate_valid).
module spike_isi_encoder
  import spike_isi_encoder_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int ISI_W = DEF_ISI_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   spike_in,
  output logic [ISI_W-1:0]       isi_data,
  output logic                   isi_valid,
  input  logic                   isi_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow
`ifdef SPIKE_RATE_WINDOW_EN
  ,
  output logic [7:0]             rate_count,
  output logic                   rate_valid
`endif
);

  localparam logic [ISI_W-1:0] ISI_MAX = '1;

  // Saturating interval increment.
  function automatic logic [ISI_W-1:0] isi_sat_inc(input logic [ISI_W-1:0] v);
    return (v == ISI_MAX) ? v : v + ISI_W'(1);
  endfunction

  logic             spike_q;
  logic             spike_edge;
  logic             armed;
  logic [ISI_W-1:0] isi_cnt;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  assign spike_edge = spike_in & ~spike_q & ena;
  assign push       = spike_edge & armed;
  assign pop        = isi_valid & isi_ready;
  assign isi_valid  = ~fifo_empty;

  // Edge detection sample, arming and interval counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_q <= 1'b0;
      armed   <= 1'b0;
      isi_cnt <= '0;
    end else begin
      spike_q <= spike_in;
      if (spike_edge) begin
        armed   <= 1'b1;
        isi_cnt <= ISI_W'(1);
      end else if (ena) begin
        isi_cnt <= isi_sat_inc(isi_cnt);
      end
    end
  end

  // Sticky drop flag: a push that found the FIFO full with no pop to make room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else if (push && fifo_full && !pop) overflow <= 1'b1;
  end

  isi_fifo #(
    .DEPTH (DEPTH),
    .ISI_W (ISI_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (isi_cnt),
    .pop   (pop),
    .rdata (isi_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

`ifdef SPIKE_RATE_WINDOW_EN
  localparam int WIN_W = $clog2(RATE_WIN_LEN);

  // Saturating 8-bit edge count.
  function automatic logic [7:0] rate_sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [WIN_W-1:0] win_timer;
  logic [7:0]       win_edges;

  // Window timer runs on enabled cycles; at wrap the count is published and
  // an edge on the wrap cycle opens the new window's count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_timer  <= '0;
      win_edges  <= '0;
      rate_count <= '0;
      rate_valid <= 1'b0;
    end else begin
      rate_valid <= 1'b0;
      if (ena) begin
        win_timer <= win_timer + WIN_W'(1);
        if (win_timer == '1) begin
          rate_count <= win_edges;
          rate_valid <= 1'b1;
          win_edges  <= spike_edge ? 8'd1 : 8'd0;
        end else if (spike_edge) begin
          win_edges <= rate_sat_inc(win_edges);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_spike_isi_encoder.sv
// Directed testbench for spike_isi_encoder (DEPTH=4, ISI_W=8).
// Cycle 0 is the first clock period after reset release.
module tb_spike_isi_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       spike_in;
  logic [7:0] isi_data;
  logic       isi_valid;
  logic       isi_ready;
  logic [2:0] fifo_level;
  logic       overflow;
`ifdef SPIKE_RATE_WINDOW_EN
  logic [7:0] rate_count;
  logic       rate_valid;
`endif

  int checks = 0;
  int errors = 0;

  spike_isi_encoder #(.DEPTH(4), .ISI_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .spike_in   (spike_in),
    .isi_data   (isi_data),
    .isi_valid  (isi_valid),
    .isi_ready  (isi_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow)
`ifdef SPIKE_RATE_WINDOW_EN
    ,
    .rate_count (rate_count),
    .rate_valid (rate_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    spike_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse();
    spike_in = 1'b1;
    tick();
    spike_in = 1'b0;
  endtask

  task automatic hold(input int n);
    spike_in = 1'b1;
    repeat (n) tick();
    spike_in = 1'b0;
  endtask

  task automatic pop1();
    isi_ready = 1'b1;
    tick();
    isi_ready = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst_n     = 1'b0;
    spike_in  = 1'b0;
    isi_ready = 1'b0;
    ena       = 1'b1;
    #1;
    chk({tag, "_rst_valid"}, isi_valid, 0);
    chk({tag, "_rst_level"}, fifo_level, 0);
    tick();
    tick();
    chk({tag, "_rst_data"}, isi_data, 0);
    chk({tag, "_rst_ovf"}, overflow, 0);
`ifdef SPIKE_RATE_WINDOW_EN
    chk({tag, "_rst_rate_cnt"}, rate_count, 0);
    chk({tag, "_rst_rate_vld"}, rate_valid, 0);
`endif
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; spike_in = 1'b0; isi_ready = 1'b0;
    tick();

    // Edges at 10, 30, 35: first discarded, entries 20 then 5.
    do_reset("t1");
    idle(10);
    pulse();
    idle(19);
    chk("t1_valid_c30", isi_valid, 0);
    chk("t1_level_c30", fifo_level, 0);
    pulse();
    chk("t1_valid_c31", isi_valid, 1);
    chk("t1_data_c31", isi_data, 20);
    idle(4);
    pulse();
    chk("t1_level_c36", fifo_level, 2);
    chk("t1_head_c36", isi_data, 20);
    pop1();
    chk("t1_pop1_data", isi_data, 5);
    chk("t1_pop1_level", fifo_level, 1);
    pop1();
    chk("t1_pop2_valid", isi_valid, 0);
    chk("t1_pop2_data", isi_data, 0);
    pop1();
    chk("t1_pop_empty_level", fifo_level, 0);
    chk("t1_pop_empty_ovf", overflow, 0);
    idle(3);
    pulse();
    chk("t1_queued_before_reset", fifo_level, 1);

    // Saturation: edges at 0 and 400 give a single 255 entry.
    do_reset("t2");
    pulse();
    idle(399);
    pulse();
    chk("t2_level", fifo_level, 1);
    chk("t2_sat_data", isi_data, 255);

    // Overflow with consumer stalled.
    do_reset("t3");
    pulse();
    idle(2); pulse();
    idle(3); pulse();
    idle(4); pulse();
    idle(5); pulse();
    chk("t3_full_level", fifo_level, 4);
    chk("t3_full_no_ovf", overflow, 0);
    idle(6); pulse();
    idle(7); pulse();
    chk("t3_ovf_level", fifo_level, 4);
    chk("t3_ovf_flag", overflow, 1);
    chk("t3_head0", isi_data, 3);
    isi_ready = 1'b1;
    tick(); chk("t3_head1", isi_data, 4);
    tick(); chk("t3_head2", isi_data, 5);
    tick(); chk("t3_head3", isi_data, 6);
    tick(); chk("t3_drained", isi_valid, 0);
    isi_ready = 1'b0;
    chk("t3_ovf_sticky", overflow, 1);

    // Full FIFO with a pop on the edge cycle: push accepted at tail.
    do_reset("t4");
    pulse();
    idle(1); pulse();
    idle(2); pulse();
    idle(3); pulse();
    idle(4); pulse();
    chk("t4_full_level", fifo_level, 4);
    idle(8);
    isi_ready = 1'b1;
    pulse();
    isi_ready = 1'b0;
    chk("t4_level_kept", fifo_level, 4);
    chk("t4_no_ovf", overflow, 0);
    chk("t4_head0", isi_data, 3);
    isi_ready = 1'b1;
    tick(); chk("t4_head1", isi_data, 4);
    tick(); chk("t4_head2", isi_data, 5);
    tick(); chk("t4_tail", isi_data, 9);
    tick(); chk("t4_drained", isi_valid, 0);
    isi_ready = 1'b0;

    // Disabled stretch freezes the counter and ignores spikes.
    do_reset("t5");
    pulse();
    idle(4);
    ena = 1'b0;
    idle(10); pulse(); idle(10); pulse(); idle(28);
    chk("t5_ignored_level", fifo_level, 0);
    ena = 1'b1;
    idle(5);
    pulse();
    chk("t5_level", fifo_level, 1);
    chk("t5_data", isi_data, 10);

    // A multi-cycle high spike is one edge.
    do_reset("t6");
    hold(5);
    idle(2);
    pulse();
    chk("t6_level", fifo_level, 1);
    chk("t6_data", isi_data, 7);

`ifdef SPIKE_RATE_WINDOW_EN
    // Seven edges in the first window, published at cycle 256.
    do_reset("t7");
    isi_ready = 1'b1;
    pulse();
    repeat (6) begin
      idle(19);
      pulse();
    end
    idle(134);
    chk("t7_rate_vld_c255", rate_valid, 0);
    tick();
    chk("t7_rate_vld_c256", rate_valid, 1);
    chk("t7_rate_cnt_c256", rate_count, 7);
    tick();
    chk("t7_rate_vld_c257", rate_valid, 0);
    chk("t7_rate_cnt_c257", rate_count, 7);
    isi_ready = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
